gpio_breakout_cond: RTL and testbench

//  Parametrised GPIO breakout with input conditioning. Fans a GPIO_WIDTH-bit

---
 rtl/gpio_breakout_pkg.sv | 25 ++
 rtl/gpio_in_cond.sv | 118 +++++++++++
 rtl/gpio_breakout_cond.sv | 109 ++++++++++
 tb/tb_gpio_breakout_cond.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_breakout_pkg.sv
// ----------------------------------------------------------------------------
// gpio_breakout_pkg
//   Shared constants, types and helpers for the conditioned GPIO breakout.
//   MAX_GPIO_WIDTH  : largest channel count the breakout generates
//   MIN_SYNC_STAGES : smallest synchroniser depth that is still metastability-safe
//   flags_t         : per-channel sticky edge flag pair
//   clog2_cnt()     : width of a debounce counter that must reach DEBOUNCE_CYCLES
// ----------------------------------------------------------------------------
package gpio_breakout_pkg;

    localparam int MAX_GPIO_WIDTH  = 32;
    localparam int MIN_SYNC_STAGES = 2;

    typedef struct packed {
        logic rise;
        logic fall;
    } flags_t;

    // Counter width for a debounce of 'cycles' cycles; never narrower than 1 bit
    // so that the degenerate cases still produce a legal vector.
    function automatic int clog2_cnt(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_in_cond.sv
// ----------------------------------------------------------------------------
// gpio_in_cond
//   One input-conditioning channel: SYNC_STAGES-deep synchroniser, debounce
//   filter and sticky rise/fall event flags.
// Ports
//   clk       in  : single clock
//   rstn      in  : synchronous reset, active-low
//   arm       in  : 0 = follow the synchronised pin directly, raise no events
//   s_i       in  : raw asynchronous pin level
//   flag_clr  in  : 1-cycle pulse clearing both flags (a same-cycle set wins)
//   m_i       out : conditioned (synchronised + debounced) level
//   rise_flag out : sticky, accepted 0->1 transition seen
//   fall_flag out : sticky, accepted 1->0 transition seen
// ----------------------------------------------------------------------------
module gpio_in_cond
    import gpio_breakout_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic arm,
    input  logic s_i,
    input  logic flag_clr,
    output logic m_i,
    output logic rise_flag,
    output logic fall_flag
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic   syn;
    logic   accept;
    logic   db_q, db_d;
    flags_t flags_q, flags_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], s_i};
        end
    end

    assign syn = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_db
            // Every armed change of the synchronised level is accepted at once.
            always_comb begin
                accept = arm && (syn != db_q);
            end
        end else begin : g_db
            localparam int CNT_W = clog2_cnt(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q, cnt_d;

            // NOTE: every combinational output gets a default first, so no path
            // leaves it unassigned and no latch is inferred.
            always_comb begin
                cnt_d  = '0;
                accept = 1'b0;
                // The counter only runs while the new level persists; any return
                // to the accepted level (or disarming) restarts it from zero.
                if (arm && (syn != db_q)) begin
                    if (cnt_q == CNT_LAST) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        // Unarmed: track the pin silently so static levels at reset are absorbed.
        db_d = (!arm || accept) ? syn : db_q;

        // Set is applied after clear so a same-cycle event is never lost.
        flags_d = flags_q;
        if (flag_clr) begin
            flags_d = '0;
        end
        if (accept && syn) begin
            flags_d.rise = 1'b1;
        end
        if (accept && !syn) begin
            flags_d.fall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            db_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            db_q    <= db_d;
            flags_q <= flags_d;
        end
    end

    assign m_i       = db_q;
    assign rise_flag = flags_q.rise;
    assign fall_flag = flags_q.fall;

endmodule

// File: rtl/gpio_breakout_cond.sv
// ----------------------------------------------------------------------------
// gpio_breakout_cond
//   GPIO breakout between an AXI/PS GPIO master and per-pin IOBUFs, with
//   conditioned inputs, sticky edge flags and a maskable level interrupt.
// Ports
//   clk, rstn          : clock, synchronous active-low reset
//   m_t, m_o      in   : master tristate (1 = Hi-Z) and output data
//   m_i           out  : conditioned input level back to the master
//   s_t, s_o      out  : per-pin IOBUF T / I (registered when REG_OUT=1)
//   s_i           in   : raw asynchronous pin level from IOBUF O
//   rise_en/fall_en in : interrupt enables per flag
//   flag_clr      in   : 1-cycle pulse clearing both flags of a bit
//   rise_flag/fall_flag out : sticky accepted-edge flags
//   irq           out  : OR of enabled flags, combinational
// ----------------------------------------------------------------------------
module gpio_breakout_cond
    import gpio_breakout_pkg::*;
#(
    parameter int GPIO_WIDTH      = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REG_OUT         = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [GPIO_WIDTH-1:0] m_t,
    input  logic [GPIO_WIDTH-1:0] m_o,
    output logic [GPIO_WIDTH-1:0] m_i,
    output logic [GPIO_WIDTH-1:0] s_t,
    output logic [GPIO_WIDTH-1:0] s_o,
    input  logic [GPIO_WIDTH-1:0] s_i,
    input  logic [GPIO_WIDTH-1:0] rise_en,
    input  logic [GPIO_WIDTH-1:0] fall_en,
    input  logic [GPIO_WIDTH-1:0] flag_clr,
    output logic [GPIO_WIDTH-1:0] rise_flag,
    output logic [GPIO_WIDTH-1:0] fall_flag,
    output logic                  irq
);

    // Out-of-range parameters are clamped rather than producing broken logic.
    localparam int SYNC_N   = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
    localparam int CH_N     = (GPIO_WIDTH > MAX_GPIO_WIDTH) ? MAX_GPIO_WIDTH : GPIO_WIDTH;
    localparam int ARM_LAST = SYNC_N + 1;
    localparam int ARM_W    = $clog2(ARM_LAST + 1);

    // Arming: the first SYNC_N+1 cycles after reset release flush the
    // synchronisers; only then are level changes treated as events.
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             armed;

    assign armed     = (arm_cnt_q == ARM_W'(ARM_LAST));
    assign arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            arm_cnt_q <= '0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
        end
    end

    generate
        for (genvar k = 0; k < CH_N; k++) begin : g_ch
            gpio_in_cond #(
                .SYNC_STAGES    (SYNC_N),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_in_cond (
                .clk      (clk),
                .rstn     (rstn),
                .arm      (armed),
                .s_i      (s_i[k]),
                .flag_clr (flag_clr[k]),
                .m_i      (m_i[k]),
                .rise_flag(rise_flag[k]),
                .fall_flag(fall_flag[k])
            );
        end

        if (GPIO_WIDTH > CH_N) begin : g_unused_ch
            assign m_i[GPIO_WIDTH-1:CH_N]       = '0;
            assign rise_flag[GPIO_WIDTH-1:CH_N] = '0;
            assign fall_flag[GPIO_WIDTH-1:CH_N] = '0;
        end

        if (REG_OUT != 0) begin : g_reg_out
            logic [GPIO_WIDTH-1:0] s_t_q, s_o_q;

            // Reset leaves every pin as a Hi-Z input until the master drives.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    s_t_q <= '1;
                    s_o_q <= '0;
                end else begin
                    s_t_q <= m_t;
                    s_o_q <= m_o;
                end
            end

            assign s_t = s_t_q;
            assign s_o = s_o_q;
        end else begin : g_comb_out
            assign s_t = m_t;
            assign s_o = m_o;
        end
    endgenerate

    assign irq = |((rise_flag & rise_en) | (fall_flag & fall_en));

endmodule

// File: tb/tb_gpio_breakout_cond.sv
// ----------------------------------------------------------------------------
// tb_gpio_breakout_cond
//   Two instances share one stimulus: dut0 with default parameters
//   (SYNC 2, debounce 4, combinational outputs) and dut1 with SYNC 3,
//   no debounce and registered outputs. A window-based reference model
//   predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_gpio_breakout_cond;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] m_t, m_o, s_i, rise_en, fall_en, flag_clr;

    logic [W-1:0] m_i0, s_t0, s_o0, rise0, fall0;
    logic [W-1:0] m_i1, s_t1, s_o1, rise1, fall1;
    logic         irq0, irq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_breakout_cond #(
        .GPIO_WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REG_OUT(0)
    ) dut0 (
        .clk(clk), .rstn(rstn), .m_t(m_t), .m_o(m_o), .m_i(m_i0),
        .s_t(s_t0), .s_o(s_o0), .s_i(s_i), .rise_en(rise_en), .fall_en(fall_en),
        .flag_clr(flag_clr), .rise_flag(rise0), .fall_flag(fall0), .irq(irq0)
    );

    gpio_breakout_cond #(
        .GPIO_WIDTH(W), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .REG_OUT(1)
    ) dut1 (
        .clk(clk), .rstn(rstn), .m_t(m_t), .m_o(m_o), .m_i(m_i1),
        .s_t(s_t1), .s_o(s_o1), .s_i(s_i), .rise_en(rise_en), .fall_en(fall_en),
        .flag_clr(flag_clr), .rise_flag(rise1), .fall_flag(fall1), .irq(irq1)
    );

    // ------------------------------------------------------------------
    // Reference model. samp[j] = pin value sampled j+1 edges ago, so the
    // synchronised level at this edge is samp[sync-1]. A change is accepted
    // once the synchronised level has differed from the accepted level on
    // 'deb' consecutive edges (hist[0..deb-1]), or immediately when deb = 0.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [7:0][W-1:0] samp;
        logic [7:0][W-1:0] hist;
        logic [31:0]       since_rel;
        logic [W-1:0]      db;
        logic [W-1:0]      rise;
        logic [W-1:0]      fall;
        logic [W-1:0]      st;
        logic [W-1:0]      so;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t model_step(input mdl_t m, input int sync_n, input int deb_n,
                                        input logic rst_n, input logic [W-1:0] pin,
                                        input logic [W-1:0] clr, input logic [W-1:0] t,
                                        input logic [W-1:0] o);
        mdl_t         n;
        logic [W-1:0] syn;
        logic [W-1:0] acc;
        n = m;
        if (!rst_n) begin
            n    = '0;
            n.st = '1;
            return n;
        end
        syn         = m.samp[sync_n-1];
        n.samp      = {m.samp[6:0], pin};
        n.hist      = {m.hist[6:0], syn};
        n.since_rel = m.since_rel + 1;
        n.st        = t;
        n.so        = o;
        acc         = '0;
        if (n.since_rel <= 32'(sync_n + 1)) begin
            n.db = syn;
        end else begin
            for (int b = 0; b < W; b++) begin
                if (deb_n == 0) begin
                    acc[b] = (syn[b] != m.db[b]);
                end else begin
                    acc[b] = 1'b1;
                    for (int j = 0; j < deb_n; j++) begin
                        if (n.hist[j][b] == m.db[b]) acc[b] = 1'b0;
                    end
                end
            end
            n.db = m.db ^ acc;
        end
        n.rise = (m.rise & ~clr) | (acc & n.db);
        n.fall = (m.fall & ~clr) | (acc & ~n.db);
        return n;
    endfunction

    always @(posedge clk) begin
        m0 <= model_step(m0, 2, 4, rstn, s_i, flag_clr, m_t, m_o);
        m1 <= model_step(m1, 3, 0, rstn, s_i, flag_clr, m_t, m_o);
    end

    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d0_m_i",  m_i0,  m0.db);
        chk("d0_rise", rise0, m0.rise);
        chk("d0_fall", fall0, m0.fall);
        chk("d0_irq",  W'(irq0), W'(|((m0.rise & rise_en) | (m0.fall & fall_en))));
        chk("d0_s_t",  s_t0,  m_t);
        chk("d0_s_o",  s_o0,  m_o);
        chk("d1_m_i",  m_i1,  m1.db);
        chk("d1_rise", rise1, m1.rise);
        chk("d1_fall", fall1, m1.fall);
        chk("d1_irq",  W'(irq1), W'(|((m1.rise & rise_en) | (m1.fall & fall_en))));
        chk("d1_s_t",  s_t1,  m1.st);
        chk("d1_s_o",  s_o1,  m1.so);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] mask;

        // 1: reset with all pins high, then release
        rstn = 1'b0; s_i = '1; m_t = '1; m_o = '0;
        rise_en = '1; fall_en = '1; flag_clr = '0;
        cyc(3);
        chk("t1_rst_m_i", m_i0, 16'h0000);
        chk("t1_rst_s_t1", s_t1, 16'hFFFF);
        chk("t1_rst_irq", W'(irq0), 16'h0000);
        rstn = 1'b1;
        cyc(2);
        chk("t1_m_i_early", m_i0, 16'h0000);
        cyc(1);
        chk("t1_m_i", m_i0, 16'hFFFF);
        chk("t1_rise", rise0, 16'h0000);
        chk("t1_irq", W'(irq0), 16'h0000);
        cyc(1);
        chk("t1_d1_m_i", m_i1, 16'hFFFF);

        // drop all pins: every bit flags a fall, then clear them
        s_i = '0;
        cyc(10);
        chk("t1_fall_all", fall0, 16'hFFFF);
        flag_clr = '1;
        cyc(1);
        flag_clr = '0;
        chk("t1_clr_fall", fall0, 16'h0000);
        chk("t1_clr_irq", W'(irq0), 16'h0000);

        // 2: clean rise on bit 3, six-cycle latency
        rise_en = 16'h0008; fall_en = '0;
        s_i[3] = 1'b1;
        cyc(5);
        chk("t2_m_i_5", m_i0, 16'h0000);
        cyc(1);
        chk("t2_m_i_6", m_i0, 16'h0008);
        chk("t2_rise", rise0, 16'h0008);
        chk("t2_irq_en", W'(irq0), 16'h0001);
        rise_en = '0;
        #1;
        chk("t2_irq_dis", W'(irq0), 16'h0000);

        // 3: 3-cycle glitch rejected, 4-cycle pulse accepted both ways
        s_i[5] = 1'b1;
        cyc(3);
        s_i[5] = 1'b0;
        cyc(12);
        chk("t3_short_m_i", m_i0, 16'h0008);
        chk("t3_short_rise", rise0, 16'h0008);
        chk("t3_short_fall", fall0, 16'h0000);
        s_i[5] = 1'b1;
        cyc(4);
        s_i[5] = 1'b0;
        cyc(14);
        chk("t3_long_rise", rise0, 16'h0028);
        chk("t3_long_fall", fall0, 16'h0020);
        chk("t3_long_m_i", m_i0, 16'h0008);

        // 4: clear coinciding with an accept on bit 3 -> new flag survives
        s_i[3] = 1'b0;
        cyc(5);
        flag_clr = 16'h0008;
        cyc(1);
        flag_clr = '0;
        chk("t4_setwin_fall", fall0, 16'h0028);
        chk("t4_setwin_rise", rise0, 16'h0020);
        chk("t4_setwin_m_i", m_i0, 16'h0000);
        rise_en = '1; fall_en = '1;
        #1;
        chk("t4_irq_pre", W'(irq0), 16'h0001);
        flag_clr = '1;
        cyc(1);
        flag_clr = '0;
        chk("t4_clr_rise", rise0, 16'h0000);
        chk("t4_clr_fall", fall0, 16'h0000);
        chk("t4_clr_irq", W'(irq0), 16'h0000);
        chk("t4_clr_d1_fall", fall1, 16'h0000);

        // 5: output path latency
        m_t = '0; m_o = 16'hA5A5;
        #1;
        chk("t5_d0_s_o", s_o0, 16'hA5A5);
        chk("t5_d0_s_t", s_t0, 16'h0000);
        chk("t5_d1_s_o_old", s_o1, 16'h0000);
        chk("t5_d1_s_t_old", s_t1, 16'hFFFF);
        cyc(1);
        chk("t5_d1_s_o", s_o1, 16'hA5A5);
        chk("t5_d1_s_t", s_t1, 16'h0000);

        // 6: reset mid-debounce, re-arm without a spurious event
        s_i[7] = 1'b1;
        cyc(4);
        rstn = 1'b0;
        cyc(1);
        chk("t6_rst_m_i", m_i0, 16'h0000);
        chk("t6_rst_rise", rise0, 16'h0000);
        chk("t6_rst_d1_rise", rise1, 16'h0000);
        rstn = 1'b1;
        cyc(3);
        chk("t6_rearm_m_i", m_i0, 16'h0080);
        cyc(10);
        chk("t6_rearm_rise", rise0, 16'h0000);
        chk("t6_rearm_fall", fall0, 16'h0000);
        chk("t6_rearm_d1_rise", rise1, 16'h0000);

        // random phase: sparse pin toggles, clears, enables, occasional reset
        for (int i = 0; i < 400; i++) begin
            mask = '0;
            for (int b = 0; b < W; b++) begin
                mask[b] = ($urandom_range(0, 5) == 0);
            end
            s_i      = s_i ^ mask;
            flag_clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) rise_en = W'($urandom);
            if ($urandom_range(0, 15) == 0) fall_en = W'($urandom);
            m_t  = W'($urandom);
            m_o  = W'($urandom);
            rstn = ($urandom_range(0, 149) != 0);
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
